nw_trace_aligner: RTL and testbench

NW_TRACE_ALIGNER -- requirements
Module: nw_trace_aligner

---
 rtl/nw_pkg.sv | 13 +
 rtl/nw_cell.sv | 55 +++++
 rtl/nw_trace_aligner.sv | 197 +++++++++++++++++++
 tb/tb_nw_trace_aligner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared encodings for the Needleman-Wunsch aligner: traceback directions and FSM states.
package nw_pkg;
    localparam logic [1:0] DIR_TOP    = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_CORNER = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TRACE,
        DONE
    } state_t;
endpackage

// File: rtl/nw_cell.sv
// One score-matrix cell: computes its best score and direction once all predecessors are valid.
module nw_cell
    import nw_pkg::*;
#(
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     pred_valid,
    input  logic [CWIDTH-1:0]        a,
    input  logic [CWIDTH-1:0]        b,
    input  logic signed [SWIDTH-1:0] w_match,
    input  logic signed [SWIDTH-1:0] w_mismatch,
    input  logic signed [SWIDTH-1:0] w_indel,
    input  logic signed [SWIDTH-1:0] corner_h,
    input  logic signed [SWIDTH-1:0] top_h,
    input  logic signed [SWIDTH-1:0] left_h,
    output logic signed [SWIDTH-1:0] h,
    output logic [1:0]               dir,
    output logic                     valid
);
    logic signed [SWIDTH-1:0] c_val, t_val, l_val, h_next;
    logic [1:0]               dir_next;

    // Ties resolve toward CORNER, then TOP.
    always_comb begin
        c_val    = corner_h + ((a == b) ? w_match : w_mismatch);
        t_val    = top_h + w_indel;
        l_val    = left_h + w_indel;
        h_next   = l_val;
        dir_next = DIR_LEFT;
        if (c_val >= t_val && c_val >= l_val) begin
            h_next   = c_val;
            dir_next = DIR_CORNER;
        end else if (t_val >= l_val) begin
            h_next   = t_val;
            dir_next = DIR_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            h     <= '0;
            dir   <= DIR_TOP;
            valid <= 1'b0;
        end else if (en && pred_valid && !valid) begin
            h     <= h_next;
            dir   <= dir_next;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/nw_trace_aligner.sv
// Wavefront Needleman-Wunsch fill over a LEN_A x LEN_B cell array, followed by a
// handshaked traceback stream from the bottom-right cell back to (0,0).
module nw_trace_aligner
    import nw_pkg::*;
#(
    parameter int LEN_A      = 10,
    parameter int LEN_B      = 10,
    parameter int CWIDTH     = 2,
    parameter int SWIDTH     = 16,
    parameter int CORD_WIDTH = 8,
    parameter int WWIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_A*CWIDTH-1:0]   s1,
    input  logic [LEN_B*CWIDTH-1:0]   s2,
    input  logic signed [WWIDTH-1:0]  w_match,
    input  logic signed [WWIDTH-1:0]  w_mismatch,
    input  logic signed [WWIDTH-1:0]  w_indel,
    output logic                      busy,
    output logic signed [SWIDTH-1:0]  score,
    output logic                      score_valid,
    output logic                      step_valid,
    input  logic                      out_ready,
    output logic [CORD_WIDTH-1:0]     step_x,
    output logic [CORD_WIDTH-1:0]     step_y,
    output logic [1:0]                step_dir,
    output logic                      step_last,
    output logic                      done
);
    localparam int MAXLEN = (LEN_A > LEN_B) ? LEN_A : LEN_B;
    localparam int YW     = (LEN_A > 1) ? $clog2(LEN_A) : 1;
    localparam int XW     = (LEN_B > 1) ? $clog2(LEN_B) : 1;

    if (SWIDTH < $clog2(MAXLEN * (2 ** (WWIDTH - 1))) + 2 || (2 ** CORD_WIDTH) < MAXLEN) begin : g_param_check
        $error("nw_trace_aligner: SWIDTH or CORD_WIDTH too small for LEN_A/LEN_B/WWIDTH");
    end

    state_t                   state_reg, state_next;
    logic [LEN_A*CWIDTH-1:0]  s1_reg;
    logic [LEN_B*CWIDTH-1:0]  s2_reg;
    logic signed [SWIDTH-1:0] wm_reg, wx_reg, wi_reg, score_reg;
    logic                     score_valid_reg;
    logic [CORD_WIDTH-1:0]    x_reg, y_reg, x_next, y_next;
    logic [1:0]               dir_reg;
    logic                     at_origin, last_valid, cell_clear, cell_en;

    logic signed [SWIDTH-1:0] h_arr     [LEN_A][LEN_B];
    logic [1:0]               dir_arr   [LEN_A][LEN_B];
    logic                     valid_arr [LEN_A][LEN_B];

    assign cell_clear = (state_reg == IDLE);
    assign cell_en    = (state_reg == FILL);
    assign last_valid = valid_arr[LEN_A-1][LEN_B-1];
    assign at_origin  = (x_reg == '0) && (y_reg == '0);

    // Row -1 / column -1 boundaries are multiples of the latched indel weight.
    for (genvar gi = 0; gi < LEN_A; gi++) begin : g_row
        for (genvar gj = 0; gj < LEN_B; gj++) begin : g_col
            localparam logic signed [SWIDTH-1:0] KI0 = SWIDTH'(gi);
            localparam logic signed [SWIDTH-1:0] KI1 = SWIDTH'(gi + 1);
            localparam logic signed [SWIDTH-1:0] KJ0 = SWIDTH'(gj);
            localparam logic signed [SWIDTH-1:0] KJ1 = SWIDTH'(gj + 1);
            logic signed [SWIDTH-1:0] corner_h, top_h, left_h;
            logic                     v_corner, v_top, v_left;

            if (gi == 0) begin : g_top
                assign top_h    = KJ1 * wi_reg;
                assign v_top    = 1'b1;
                assign corner_h = KJ0 * wi_reg;
                assign v_corner = 1'b1;
            end else begin : g_top
                assign top_h = h_arr[gi-1][gj];
                assign v_top = valid_arr[gi-1][gj];
                if (gj == 0) begin : g_corner
                    assign corner_h = KI0 * wi_reg;
                    assign v_corner = 1'b1;
                end else begin : g_corner
                    assign corner_h = h_arr[gi-1][gj-1];
                    assign v_corner = valid_arr[gi-1][gj-1];
                end
            end

            if (gj == 0) begin : g_left
                assign left_h = KI1 * wi_reg;
                assign v_left = 1'b1;
            end else begin : g_left
                assign left_h = h_arr[gi][gj-1];
                assign v_left = valid_arr[gi][gj-1];
            end

            nw_cell #(
                .CWIDTH(CWIDTH),
                .SWIDTH(SWIDTH)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .clear     (cell_clear),
                .en        (cell_en),
                .pred_valid(v_corner && v_top && v_left),
                .a         (s1_reg[(LEN_A-1-gi)*CWIDTH +: CWIDTH]),
                .b         (s2_reg[(LEN_B-1-gj)*CWIDTH +: CWIDTH]),
                .w_match   (wm_reg),
                .w_mismatch(wx_reg),
                .w_indel   (wi_reg),
                .corner_h  (corner_h),
                .top_h     (top_h),
                .left_h    (left_h),
                .h         (h_arr[gi][gj]),
                .dir       (dir_arr[gi][gj]),
                .valid     (valid_arr[gi][gj])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        busy        = (state_reg != IDLE);
        step_valid  = (state_reg == TRACE);
        step_last   = (state_reg == TRACE) && at_origin;
        done        = (state_reg == DONE);
        case (state_reg)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (last_valid) state_next = TRACE;
            TRACE:   if (out_ready && at_origin) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Matrix edges force the walk along the boundary regardless of stored direction.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (x_reg == '0) begin
            y_next = y_reg - 1'b1;
        end else if (y_reg == '0 || dir_reg == DIR_LEFT) begin
            x_next = x_reg - 1'b1;
        end else if (dir_reg == DIR_TOP) begin
            y_next = y_reg - 1'b1;
        end else begin
            x_next = x_reg - 1'b1;
            y_next = y_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg          <= '0;
            s2_reg          <= '0;
            wm_reg          <= '0;
            wx_reg          <= '0;
            wi_reg          <= '0;
            score_reg       <= '0;
            score_valid_reg <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            dir_reg         <= DIR_TOP;
        end else begin
            if (state_reg == IDLE && start) begin
                s1_reg          <= s1;
                s2_reg          <= s2;
                wm_reg          <= SWIDTH'(w_match);
                wx_reg          <= SWIDTH'(w_mismatch);
                wi_reg          <= SWIDTH'(w_indel);
                score_valid_reg <= 1'b0;
            end
            if (state_reg == FILL && last_valid) begin
                score_reg       <= h_arr[LEN_A-1][LEN_B-1];
                score_valid_reg <= 1'b1;
                x_reg           <= CORD_WIDTH'(LEN_B - 1);
                y_reg           <= CORD_WIDTH'(LEN_A - 1);
                dir_reg         <= dir_arr[LEN_A-1][LEN_B-1];
            end
            if (state_reg == TRACE && out_ready && !at_origin) begin
                x_reg   <= x_next;
                y_reg   <= y_next;
                dir_reg <= dir_arr[YW'(y_next)][XW'(x_next)];
            end
        end
    end

    assign score       = score_reg;
    assign score_valid = score_valid_reg;
    assign step_x      = x_reg;
    assign step_y      = y_reg;
    assign step_dir    = dir_reg;
endmodule

// File: tb/tb_nw_trace_aligner.sv
// Scoreboard bench: a dynamic-programming reference model queues the expected score and
// traceback; a negedge monitor compares every transferred step, score and done pulse.
module tb_nw_trace_aligner;
    localparam int LA = 4, LB = 4, CW = 2, SW = 16, CDW = 8, WW = 8;
    localparam int NONE = -100000;

    logic                 clk = 1'b0;
    logic                 reset, start, out_ready;
    logic [LA*CW-1:0]     s1;
    logic [LB*CW-1:0]     s2;
    logic signed [WW-1:0] w_match, w_mismatch, w_indel;
    logic                 busy, score_valid, step_valid, step_last, done;
    logic signed [SW-1:0] score;
    logic [CDW-1:0]       step_x, step_y;
    logic [1:0]           step_dir;

    typedef struct {
        int x;
        int y;
        int dir;
        int last;
    } step_t;

    step_t exp_steps[$];
    int    exp_score[$];
    int    n_cmp = 0, n_fail = 0;
    int    hold_low = 0;

    nw_trace_aligner #(
        .LEN_A(LA), .LEN_B(LB), .CWIDTH(CW), .SWIDTH(SW), .CORD_WIDTH(CDW), .WWIDTH(WW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .w_match(w_match), .w_mismatch(w_mismatch), .w_indel(w_indel),
        .busy(busy), .score(score), .score_valid(score_valid),
        .step_valid(step_valid), .out_ready(out_ready),
        .step_x(step_x), .step_y(step_y), .step_dir(step_dir),
        .step_last(step_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Full DP matrix with explicit boundary row/column, then a walk back from the corner.
    task automatic model_push(input logic [LA*CW-1:0] a, input logic [LB*CW-1:0] b,
                              input int wm, input int wx, input int wi);
        int h [LA+1][LB+1];
        int d [LA][LB];
        int c, t, l, x, y;
        for (int i = 0; i <= LA; i++) h[i][0] = i * wi;
        for (int j = 0; j <= LB; j++) h[0][j] = j * wi;
        for (int i = 0; i < LA; i++) begin
            for (int j = 0; j < LB; j++) begin
                c = h[i][j] + ((a[(LA-1-i)*CW +: CW] == b[(LB-1-j)*CW +: CW]) ? wm : wx);
                t = h[i][j+1] + wi;
                l = h[i+1][j] + wi;
                if (c >= t && c >= l) begin
                    h[i+1][j+1] = c; d[i][j] = 2;
                end else if (t >= l) begin
                    h[i+1][j+1] = t; d[i][j] = 0;
                end else begin
                    h[i+1][j+1] = l; d[i][j] = 1;
                end
            end
        end
        exp_score.push_back(h[LA][LB]);
        x = LB - 1;
        y = LA - 1;
        forever begin
            exp_steps.push_back('{x: x, y: y, dir: d[y][x], last: (x == 0 && y == 0) ? 1 : 0});
            if (x == 0 && y == 0) break;
            if (x == 0) y--;
            else if (y == 0) x--;
            else if (d[y][x] == 0) y--;
            else if (d[y][x] == 1) x--;
            else begin x--; y--; end
        end
    endtask

    // out_ready driver: random backpressure, or forced low for hold_low cycles.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_low > 0) begin
                out_ready = 1'b0;
                hold_low--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops and compares on each DUT output event.
    initial begin
        int    sv_prev = 0, hold_prev = 0, last_prev = 0;
        int    hx = 0, hy = 0, hd = 0, hl = 0;
        step_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                sv_prev = 0; hold_prev = 0; last_prev = 0;
            end else begin
                if (hold_prev != 0) begin
                    chk("hold_valid", step_valid, 1);
                    chk("hold_x", step_x, hx);
                    chk("hold_y", step_y, hy);
                    chk("hold_dir", step_dir, hd);
                    chk("hold_last", step_last, hl);
                end
                chk("done_pulse", done, last_prev);
                if (last_prev != 0) chk("valid_after_last", step_valid, 0);
                if (score_valid && sv_prev == 0) begin
                    if (exp_score.size() == 0) chk("unexpected_score", 1, 0);
                    else chk("score", score, exp_score.pop_front());
                end
                if (step_valid && out_ready) begin
                    if (exp_steps.size() == 0) begin
                        chk("unexpected_step", 1, 0);
                    end else begin
                        e = exp_steps.pop_front();
                        chk("step_x", step_x, e.x);
                        chk("step_y", step_y, e.y);
                        chk("step_dir", step_dir, e.dir);
                        chk("step_last", step_last, e.last);
                    end
                end
                hold_prev = (step_valid && !out_ready) ? 1 : 0;
                hx = step_x; hy = step_y; hd = step_dir; hl = step_last;
                last_prev = (step_valid && out_ready && step_last) ? 1 : 0;
                sv_prev   = score_valid;
            end
        end
    end

    task automatic run(input logic [LA*CW-1:0] a, input logic [LB*CW-1:0] b,
                       input int wm, input int wx, input int wi,
                       input int exp_sc, input bit inject_start, input int hold);
        bit seen_sv = 0, seen_done = 0;
        model_push(a, b, wm, wx, wi);
        s1 = a; s2 = b;
        w_match = WW'(wm); w_mismatch = WW'(wx); w_indel = WW'(wi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s1 = ~a; s2 = ~b;
        w_match = WW'($urandom); w_mismatch = WW'($urandom); w_indel = WW'($urandom);
        for (int n = 1; n <= 80; n++) begin
            if (inject_start && n == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("busy_run", busy, 1);
            if (score_valid && !seen_sv) begin
                seen_sv = 1;
                chk("score_edge", n, LA + LB);
                chk("step_valid_edge", step_valid, 1);
                if (exp_sc != NONE) chk("score_directed", score, exp_sc);
                if (hold > 0) hold_low = hold;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        chk("run_completed", seen_done, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        chk("score_held", score_valid, 1);
        $display("run s1=%h s2=%h w=%0d/%0d/%0d score=%0d", a, b, wm, wx, wi, score);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        s1 = '0; s2 = '0; w_match = '0; w_mismatch = '0; w_indel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_score_valid", score_valid, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_step_last", step_last, 0);
        chk("rst_done", done, 0);
        chk("rst_score", score, 0);
        chk("rst_step_x", step_x, 0);
        chk("rst_step_y", step_y, 0);
        chk("rst_step_dir", step_dir, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run(8'h1B, 8'h1B, 1, -1, -1, 4, 0, 0);
        run(8'h1B, 8'h1B, 1, -1, -1, 4, 0, 5);
        run(8'h1B, 8'h1B, 1, -1, -1, 4, 1, 0);
        run(8'h00, 8'hFF, 2, -3, -2, -12, 0, 0);

        // Abort mid-fill: reset sampled at edge 2 after acceptance.
        s1 = 8'h1B; s2 = 8'h1B; w_match = 8'sd1; w_mismatch = -8'sd1; w_indel = -8'sd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_steps.delete();
        exp_score.delete();
        chk("abort_busy", busy, 0);
        chk("abort_score_valid", score_valid, 0);
        chk("abort_step_valid", step_valid, 0);
        chk("abort_done", done, 0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_step", step_valid, 0);
        end
        run(8'h1B, 8'h1B, 1, -1, -1, 4, 0, 0);

        for (int r = 0; r < 24; r++) begin
            if (r % 2 == 0)
                run(8'($urandom), 8'($urandom), int'($urandom_range(0, 8)) - 4,
                    int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4, NONE, 0, 0);
            else
                run(8'($urandom), 8'($urandom), int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                    NONE, 0, int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("steps_drained", exp_steps.size(), 0);
        chk("scores_drained", exp_score.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
